// File: rtl/gpr_pkg.sv
// Shared types, defaults and read-source selection for the GPR file with scoreboard.
// Combinational helpers only; no state lives here.
package gpr_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NR_REG_DEF   = 16;
    localparam int PEND_MAX_DEF = 3;

    typedef logic [$clog2(NR_REG_DEF)-1:0]     reg_idx_t;
    typedef logic [$clog2(PEND_MAX_DEF+1)-1:0] sb_cnt_t;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_BYP  = 2'd1,
        SRC_ARR  = 2'd2
    } rd_src_e;

    // Index 0 always wins over a bypass hit so x0 can never leak writeback data.
    function automatic rd_src_e rd_src(input logic zero_addr, input logic wb_hit);
        if (zero_addr)
            return SRC_ZERO;
        else if (wb_hit)
            return SRC_BYP;
        else
            return SRC_ARR;
    endfunction

endpackage

// File: rtl/gpr_sb_counter.sv
// Per-register pending-write counter: saturates at PEND_MAX, holds at zero on a stray writeback.
// Updates one cycle after inc/dec; flush and reset clear it and drop any same-cycle inc.
module gpr_sb_counter #(
    parameter  int PEND_MAX = 3,
    localparam int CW       = $clog2(PEND_MAX+1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    input  logic          flush,
    output logic [CW-1:0] cnt,
    output logic          full
);

    logic inc_eff;
    logic dec_eff;

    assign full    = (cnt == CW'(PEND_MAX));
    assign inc_eff = inc && !full;
    // A writeback with nothing outstanding is an underflow: the count stays at zero.
    assign dec_eff = dec && (cnt != '0);

    always_ff @(posedge clock) begin
        if (reset || flush)
            cnt <= '0;
        else if (inc_eff && !dec_eff)
            cnt <= cnt + 1'b1;
        else if (dec_eff && !inc_eff)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/gpr_file_sb.sv
// Parametrised GPR file with zero-latency bypassed reads and per-register pending-write scoreboard.
// Writeback is always accepted; issue is throttled through iss_ready when a register has PEND_MAX writes in flight.
module gpr_file_sb
    import gpr_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NR_REG   = NR_REG_DEF,
    parameter  int NR_RD    = 2,
    parameter  int PEND_MAX = PEND_MAX_DEF,
    localparam int AW       = $clog2(NR_REG),
    localparam int CW       = $clog2(PEND_MAX+1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [NR_RD*AW-1:0]   raddr,
    output logic [NR_RD*XLEN-1:0] rdata,
    output logic [NR_RD-1:0]      rbusy,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ready,
    input  logic                  flush,
    output logic                  sb_err
);

    logic [XLEN-1:0]   regs [NR_REG];
    logic [CW-1:0]     cnt  [NR_REG];
    logic [NR_REG-1:0] full;
    logic [NR_REG-1:0] inc;
    logic [NR_REG-1:0] dec;
    logic              do_inc;
    logic              wb_live;

    assign wb_live   = wen && (waddr != '0);
    // Ready deliberately ignores a same-cycle writeback to keep this path short.
    assign iss_ready = (iss_rd == '0) || !full[iss_rd];
    assign do_inc    = iss_valid && iss_ready && (iss_rd != '0) && !flush;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NR_REG; k++)
                regs[k] <= '0;
        end else if (wb_live) begin
            regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            sb_err <= 1'b0;
        else if (wb_live && cnt[waddr] == '0)
            sb_err <= 1'b1;
    end

    for (genvar k = 0; k < NR_REG; k++) begin : g_sb
        assign inc[k] = do_inc && (iss_rd == AW'(k));
        assign dec[k] = wen && (waddr == AW'(k));
        if (k == 0) begin : g_zero
            assign cnt[k]  = '0;
            assign full[k] = 1'b0;
        end else begin : g_cnt
            gpr_sb_counter #(.PEND_MAX(PEND_MAX)) u_cnt (
                .clock (clock),
                .reset (reset),
                .inc   (inc[k]),
                .dec   (dec[k]),
                .flush (flush),
                .cnt   (cnt[k]),
                .full  (full[k])
            );
        end
    end

    for (genvar i = 0; i < NR_RD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        rd_src_e       src;

        assign ra  = raddr[i*AW +: AW];
        assign hit = wen && (waddr == ra);
        assign src = rd_src(ra == '0, hit);

        assign rdata[i*XLEN +: XLEN] = (src == SRC_ZERO) ? '0 :
                                       (src == SRC_BYP)  ? wdata : regs[ra];
        // The final outstanding write landing this cycle already shows up on rdata, so not busy.
        assign rbusy[i] = (cnt[ra] != '0) && !(hit && cnt[ra] == CW'(1));
    end

endmodule
